// File: rtl/dfu_axi_pkg.sv
// dfu_axi_pkg: shared FSM states, AXI response codes and address helper for the DFU read bridge.
package dfu_axi_pkg;
  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, ERR} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/rd_beat_fifo.sv
// rd_beat_fifo: synchronous beat FIFO with registered storage, count and flush.
module rd_beat_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wr ? wp + AW'(1) : wp;
      rp    <= rd ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/dfu_axi_rd_bridge.sv
// dfu_axi_rd_bridge: AXI4 read slave that turns each burst into one DFU read request
// and replays the buffered DFU beat stream on the R channel.
module dfu_axi_rd_bridge
  import dfu_axi_pkg::*;
#(
  parameter int SRAM_ADDR_W     = 8,
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_RDATA_WIDTH = 256,
  parameter int AXI_ID_W        = 4,
  parameter int ROW             = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int TIMEOUT         = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ID_W-1:0]        s_axi_arid,
  input  logic [AXI_ADDR_W-1:0]      s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_ID_W-1:0]        s_axi_rid,
  output logic [AXI_RDATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [SRAM_ADDR_W-1:0]     ar2dfu_axi_addr,
  output logic                       ar2dfu_axi_addr_vld,
  input  logic [AXI_RDATA_WIDTH-1:0] dfu2ar_axi_data_out,
  input  logic                       dfu2ar_axi_data_out_vld,
  input  logic                       dfu2ar_axi_rd_last,
  input  logic                       ack_sram_c_rd,
  output logic                       bridge_err
);
  localparam int LSB = addr_lsb(AXI_RDATA_WIDTH);
  localparam int CW  = $clog2(ROW + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int FW  = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(ROW - 1);
  state_t                     state;
  logic [AXI_ID_W-1:0]        id_q;
  logic [7:0]                 len_q, out_cnt;
  logic [SRAM_ADDR_W-1:0]     addr_q;
  logic [1:0]                 resp_q;
  logic [CW-1:0]              in_cnt;
  logic [TW-1:0]              tmo;
  logic                       vld_q, err_q;
  logic                       push, pop, hs, full, empty;
  logic [FW:0]                count;
  logic [AXI_RDATA_WIDTH-1:0] dout;
  logic                       unused_ack;
  assign unused_ack          = ack_sram_c_rd;
  assign push                = dfu2ar_axi_data_out_vld && (state == REQ || state == FILL);
  assign pop                 = s_axi_rready && !empty && state != ERR;
  assign hs                  = s_axi_rvalid && s_axi_rready;
  assign s_axi_arready       = state == IDLE && !rst;
  assign s_axi_rvalid        = state == ERR || count != '0;
  assign s_axi_rlast         = s_axi_rvalid && out_cnt == ((state == ERR) ? len_q : LAST);
  assign s_axi_rresp         = (state == ERR) ? resp_q : RESP_OKAY;
  assign s_axi_rdata         = (state == ERR || empty) ? '0 : dout;
  assign s_axi_rid           = id_q;
  assign ar2dfu_axi_addr     = addr_q;
  assign ar2dfu_axi_addr_vld = vld_q;
  assign bridge_err          = err_q;
  rd_beat_fifo #(.DEPTH(FIFO_DEPTH), .W(AXI_RDATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (state == ERR),
    .push  (push),
    .pop   (pop),
    .din   (dfu2ar_axi_data_out),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      resp_q  <= RESP_OKAY;
      in_cnt  <= '0;
      out_cnt <= '0;
      tmo     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // stray beats, overflow and a misplaced DFU last all latch the sticky error
      if (dfu2ar_axi_data_out_vld && (state == IDLE || state == DRAIN)) err_q <= 1'b1;
      if (push && (full || (dfu2ar_axi_rd_last && in_cnt != CW'(ROW - 1)))) err_q <= 1'b1;
      if (hs) out_cnt <= s_axi_rlast ? '0 : out_cnt + 8'd1;
      case (state)
        IDLE: if (s_axi_arvalid) begin
          id_q   <= s_axi_arid;
          len_q  <= s_axi_arlen;
          addr_q <= s_axi_araddr[LSB +: SRAM_ADDR_W];
          in_cnt <= '0;
          tmo    <= '0;
          if ((s_axi_araddr >> (LSB + SRAM_ADDR_W)) != '0) begin
            state  <= ERR;
            resp_q <= RESP_DECERR;
          end else if (s_axi_arlen != LAST) begin
            state  <= ERR;
            resp_q <= RESP_SLVERR;
          end else begin
            state  <= REQ;
            resp_q <= RESP_OKAY;
            vld_q  <= 1'b1;
          end
        end
        REQ: if (dfu2ar_axi_data_out_vld) begin
          vld_q  <= 1'b0;
          in_cnt <= CW'(1);
          state  <= (ROW == 1) ? DRAIN : FILL;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          vld_q  <= 1'b0;
          resp_q <= RESP_SLVERR;
          err_q  <= 1'b1;
          state  <= ERR;
        end else tmo <= tmo + TW'(1);
        FILL: if (dfu2ar_axi_data_out_vld) begin
          in_cnt <= in_cnt + CW'(1);
          if (in_cnt == CW'(ROW - 1)) state <= DRAIN;
        end
        DRAIN, ERR: if (hs && s_axi_rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dfu_axi_rd_bridge.sv
// tb_dfu_axi_rd_bridge: directed bench with a beat-queue model of the expected R stream.
module tb_dfu_axi_rd_bridge;
  localparam int ROW = 8;
  localparam int HI  = $clog2(256 / 8) + 8;
  typedef struct {
    logic [255:0] d;
    logic [1:0]   r;
    logic         l;
    logic [3:0]   id;
  } beat_t;
  logic         clk = 0, rst = 1;
  logic [3:0]   arid = 0;
  logic [31:0]  araddr = 0;
  logic [7:0]   arlen = 0;
  logic         arvalid = 0, arready;
  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready = 1;
  logic [7:0]   dfu_addr;
  logic         dfu_addr_vld;
  logic [255:0] dfu_data = 0;
  logic         dfu_vld = 0, dfu_last = 0, dfu_ack = 0;
  logic         berr;
  int           tests = 0, fails = 0;
  beat_t        exp_q[$];
  logic [255:0] rx[$];
  logic [3:0]   cur_id;
  bit           go = 0, rr_mode = 0, chk_ar = 0, stall_prev = 0;
  beat_t        prev;
  int           vld_cycles = 0;
  dfu_axi_rd_bridge dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ar2dfu_axi_addr(dfu_addr), .ar2dfu_axi_addr_vld(dfu_addr_vld),
    .dfu2ar_axi_data_out(dfu_data), .dfu2ar_axi_data_out_vld(dfu_vld),
    .dfu2ar_axi_rd_last(dfu_last), .ack_sram_c_rd(dfu_ack),
    .bridge_err(berr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst || !go) begin
      stall_prev = 0;
      chk_ar = 0;
    end else begin
      if (dfu_addr_vld) vld_cycles++;
      if (chk_ar) begin
        check("arready_after_last", arready, 1);
        chk_ar = 0;
      end
      if (stall_prev) begin
        check("stall_rvalid", rvalid, 1);
        check("stall_payload", {rdata, rresp, rlast, rid}, {prev.d, prev.r, prev.l, prev.id});
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check("extra_beat", rdata, 256'hDEAD);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check("rdata", rdata, e.d);
          check("rresp", rresp, e.r);
          check("rlast", rlast, e.l);
          check("rid", rid, e.id);
          if (e.l) chk_ar = 1;
        end
        rx.push_back(rdata);
      end
      stall_prev = rvalid && !rready;
      prev = '{rdata, rresp, rlast, rid};
    end
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; rr_mode; k++) begin
      rready = (k % 3 == 0);
      @(posedge clk);
      #1;
    end
    rready = 1;
  end
  task automatic push_err(input int n, input logic [1:0] r);
    for (int i = 0; i < n; i++) exp_q.push_back('{256'd0, r, i == n - 1, cur_id});
  endtask
  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input bit silent);
    bit good;
    int n;
    cur_id = id;
    good = (addr >> HI) == 0 && len == 8'(ROW - 1);
    if ((addr >> HI) != 0) push_err(len + 1, 2'b11);
    else if (len != 8'(ROW - 1)) push_err(len + 1, 2'b10);
    else if (silent) push_err(ROW, 2'b10);
    @(posedge clk);
    #1;
    arid = id; araddr = addr; arlen = len; arvalid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 50);
    check("ar_accept", n < 50, 1);
    @(posedge clk);
    #1;
    arvalid = 0;
    @(negedge clk);
    check("req_vld", dfu_addr_vld, good);
    if (good) check("req_addr", dfu_addr, 8'((addr >> (HI - 8)) & 32'hFF));
    else check("err_first_beat", rvalid, 1);
  endtask
  task automatic dfu(input int delay, input int n, input int last_at);
    repeat (delay) @(posedge clk);
    #1;
    for (int k = 1; k <= n; k++) begin
      dfu_data = 256'(k); dfu_vld = 1; dfu_last = (k == last_at);
      if (k <= ROW) exp_q.push_back('{256'(k), 2'b00, k == ROW, cur_id});
      @(posedge clk);
      #1;
    end
    dfu_vld = 0; dfu_last = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !arready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("burst_done", n < 400, 1);
  endtask
  task automatic check_reset_vals();
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_req_vld", dfu_addr_vld, 0);
    check("rst_req_addr", dfu_addr, 0);
    check("rst_err", berr, 0);
  endtask
  initial begin
    int vc0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("arready_in_rst", arready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_reset_vals();
    go = 1;
    // plain burst
    rx.delete();
    ar(4'h5, 32'h60, 8'd7, 0);
    check("addr_pin", dfu_addr, 8'd3);
    dfu(3, 8, 8);
    wait_done();
    check("beats_seen", rx.size(), 8);
    check("first_beat", rx[0], 256'h1);
    check("last_beat", rx[7], 256'h8);
    check("rid_pin", rid, 4'h5);
    check("err_clean", berr, 0);
    // same burst under RREADY backpressure
    rx.delete();
    rr_mode = 1;
    ar(4'h9, 32'h60, 8'd7, 0);
    dfu(3, 8, 8);
    wait_done();
    rr_mode = 0;
    check("stall_beats", rx.size(), 8);
    check("stall_err", berr, 0);
    // illegal length and out-of-range address
    vc0 = vld_cycles;
    rx.delete();
    ar(4'h2, 32'h60, 8'd3, 0);
    wait_done();
    check("slverr_beats", rx.size(), 4);
    ar(4'h3, 32'h10000, 8'd3, 0);
    wait_done();
    check("err_no_req", vld_cycles - vc0, 0);
    check("err_paths_no_flag", berr, 0);
    // DFU never answers
    rx.delete();
    ar(4'h7, 32'h20, 8'd7, 1);
    wait_done();
    check("timeout_beats", rx.size(), 8);
    check("timeout_err", berr, 1);
    @(posedge clk);
    #1;
    rst = 1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    // early DFU last marker
    @(negedge clk);
    check("err_cleared", berr, 0);
    rx.delete();
    ar(4'h1, 32'h40, 8'd7, 0);
    dfu(3, 8, 5);
    wait_done();
    check("early_last_beats", rx.size(), 8);
    check("early_last_err", berr, 1);
    // reset in the middle of FILL
    ar(4'hA, 32'h60, 8'd7, 0);
    dfu(3, 3, 0);
    rst = 1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_reset_vals();
    rx.delete();
    ar(4'hC, 32'hA0, 8'd7, 0);
    dfu(2, 8, 8);
    wait_done();
    check("post_rst_beats", rx.size(), 8);
    check("post_rst_err", berr, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
